// File: rtl/c2h_frame_packer.sv
// rtl/c2h_frame_packer.sv - packs a narrow word stream LSB-first into wide frames
// Double-buffered: the fill slot collects words while the out slot is offered to the writer.
module c2h_frame_packer #(
   parameter int FRAME_W = 4072,
   parameter int IN_W    = 8,
   parameter int CNT_W   = 9
) (
   input  logic               m_axis_c2h_aclk,
   input  logic               m_axis_c2h_areset,
   input  logic               clr,
   input  logic [IN_W-1:0]    s_data,
   input  logic               s_valid,
   input  logic               s_last,
   output logic               s_ready,
   output logic [FRAME_W-1:0] data,
   output logic               data_valid,
   input  logic               data_next,
   output logic [15:0]        frames_done,
   output logic [CNT_W-1:0]   fill_level
);

   localparam int NWORDS = FRAME_W / IN_W;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

   generate
      if (FRAME_W % IN_W != 0) begin : g_bad_frame_w
         $error("FRAME_W must be a multiple of IN_W");
      end
      if ((2 ** CNT_W) < NWORDS) begin : g_bad_cnt_w
         $error("CNT_W too narrow for FRAME_W/IN_W words");
      end
   endgenerate

   typedef enum logic [1:0] {FILL, DONE, HELD} fill_state_e;

   fill_state_e        state_q;
   logic [FRAME_W-1:0] fill_q;
   logic [FRAME_W-1:0] out_q;
   logic [CNT_W-1:0]   level_q;
   logic               out_valid_q;
   logic               data_next_q;
   logic [15:0]        done_q;

   logic accept;
   logic complete;
   logic retire;
   logic transfer;

   assign s_ready  = (state_q == FILL);
   assign accept   = s_valid && s_ready;
   assign complete = accept && (s_last || (level_q == LAST_IDX));
   assign retire   = data_next && !data_next_q && out_valid_q;
   // A retiring out slot can be reloaded in the same cycle, so no bubble between frames.
   assign transfer = (state_q != FILL) && (!out_valid_q || retire);

   always_ff @(posedge m_axis_c2h_aclk) begin
      if (m_axis_c2h_areset || clr) begin
         state_q     <= FILL;
         fill_q      <= '0;
         out_q       <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         data_next_q <= 1'b0;
         done_q      <= '0;
      end else begin
         data_next_q <= data_next;
         if (retire) begin
            done_q <= done_q + 16'd1;
         end
         if (transfer) begin
            out_q       <= fill_q;
            out_valid_q <= 1'b1;
         end else if (retire) begin
            out_valid_q <= 1'b0;
         end
         case (state_q)
            FILL: begin
               if (accept) begin
                  fill_q[int'(level_q) * IN_W +: IN_W] <= s_data;
                  level_q <= level_q + CNT_W'(1);
                  if (complete) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE, HELD: begin
               // The fill slot is zeroed on hand-off so short frames read zero-padded.
               if (transfer) begin
                  fill_q  <= '0;
                  level_q <= '0;
                  state_q <= FILL;
               end else begin
                  state_q <= HELD;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign data        = out_q;
   assign data_valid  = out_valid_q;
   assign frames_done = done_q;
   assign fill_level  = level_q;

endmodule
